// File: rtl/fwd_hazard_unit.sv
// Hazard detection and forwarding-select controller for a D/E/M/W MIPS pipeline.
// Optional multiply/divide busy stall is built when FWD_MDU_EN is defined.
module fwd_hazard_unit #(
    parameter int AW      = 5,
    parameter int TW      = 2,
    parameter int MDU_LAT = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] d_rs,
    input  logic [AW-1:0] d_rt,
    input  logic          d_use_rs,
    input  logic          d_use_rt,
    input  logic [TW-1:0] d_tuse_rs,
    input  logic [TW-1:0] d_tuse_rt,
    input  logic [AW-1:0] d_wreg,
    input  logic [TW-1:0] d_tnew,
    input  logic          d_pc8,
    input  logic          d_is_mdu,
    input  logic          mdu_start,
    input  logic          flush,
    output logic          stall,
    output logic [1:0]    fwd_rs_d,
    output logic [1:0]    fwd_rt_d,
    output logic [1:0]    fwd_rs_e,
    output logic [1:0]    fwd_rt_e,
    output logic          fwd_rt_m,
    output logic          mdu_busy
);

    logic          e_valid, e_pc8;
    logic [AW-1:0] e_rs, e_rt, e_wreg;
    logic [TW-1:0] e_tnew;
    logic          m_valid, m_pc8;
    logic [AW-1:0] m_rt, m_wreg;
    logic [TW-1:0] m_tnew;
    logic          w_valid;
    logic [AW-1:0] w_wreg;

    logic e_hit_rs, e_hit_rt, m_hit_rs, m_hit_rt;
    logic me_hit_rs, me_hit_rt, we_hit_rs, we_hit_rt;
    logic pipe_stall, mdu_stall;

    function automatic logic hit(input logic v, input logic [AW-1:0] w, input logic [AW-1:0] r);
        return v && (w != '0) && (w == r);
    endfunction

    // A matching producer in E shadows any older one in M: its value is not
    // available to D yet, so nothing is forwarded from M.
    function automatic logic [1:0] sel_d(input logic eh, input logic mh);
        if (eh)
            return 2'b00;
        else if (mh && m_tnew == '0)
            return m_pc8 ? 2'b10 : 2'b01;
        else
            return 2'b00;
    endfunction

    function automatic logic [1:0] sel_e(input logic mh, input logic wh);
        if (!e_valid)
            return 2'b00;
        else if (mh)
            return (m_tnew == '0) ? (m_pc8 ? 2'b11 : 2'b10) : 2'b00;
        else if (wh)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign e_hit_rs  = hit(e_valid, e_wreg, d_rs);
    assign e_hit_rt  = hit(e_valid, e_wreg, d_rt);
    assign m_hit_rs  = hit(m_valid, m_wreg, d_rs);
    assign m_hit_rt  = hit(m_valid, m_wreg, d_rt);
    assign me_hit_rs = hit(m_valid, m_wreg, e_rs);
    assign me_hit_rt = hit(m_valid, m_wreg, e_rt);
    assign we_hit_rs = hit(w_valid, w_wreg, e_rs);
    assign we_hit_rt = hit(w_valid, w_wreg, e_rt);

    assign pipe_stall =
        (d_use_rs && ((e_hit_rs && e_tnew > d_tuse_rs) || (m_hit_rs && m_tnew > d_tuse_rs))) ||
        (d_use_rt && ((e_hit_rt && e_tnew > d_tuse_rt) || (m_hit_rt && m_tnew > d_tuse_rt)));

    // Gated by rst_n so every output is low as soon as reset is applied.
    assign stall = rst_n && (pipe_stall || mdu_stall);

    always_comb begin
        fwd_rs_d = sel_d(e_hit_rs, m_hit_rs);
        fwd_rt_d = sel_d(e_hit_rt, m_hit_rt);
        fwd_rs_e = sel_e(me_hit_rs, we_hit_rs);
        fwd_rt_e = sel_e(me_hit_rt, we_hit_rt);
        fwd_rt_m = m_valid && hit(w_valid, w_wreg, m_rt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_valid <= 1'b0;
            e_rs    <= '0;
            e_rt    <= '0;
            e_wreg  <= '0;
            e_tnew  <= '0;
            e_pc8   <= 1'b0;
            m_valid <= 1'b0;
            m_rt    <= '0;
            m_wreg  <= '0;
            m_tnew  <= '0;
            m_pc8   <= 1'b0;
            w_valid <= 1'b0;
            w_wreg  <= '0;
        end else begin
            w_valid <= m_valid;
            w_wreg  <= m_wreg;
            m_valid <= e_valid;
            m_rt    <= e_rt;
            m_wreg  <= e_wreg;
            m_tnew  <= (e_tnew == '0) ? '0 : e_tnew - TW'(1);
            m_pc8   <= e_pc8;
            if (flush || stall) begin
                e_valid <= 1'b0;
            end else begin
                e_valid <= 1'b1;
                e_rs    <= d_rs;
                e_rt    <= d_rt;
                e_wreg  <= d_wreg;
                e_tnew  <= d_tnew;
                e_pc8   <= d_pc8;
            end
        end
    end

`ifdef FWD_MDU_EN
    localparam int CW = $clog2(MDU_LAT + 1);
    logic [CW-1:0] mdu_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mdu_cnt <= '0;
        else if (mdu_start)
            mdu_cnt <= CW'(MDU_LAT);
        else if (mdu_cnt != '0)
            mdu_cnt <= mdu_cnt - CW'(1);
    end

    assign mdu_busy  = rst_n && (mdu_cnt != '0);
    assign mdu_stall = d_is_mdu && (mdu_busy || mdu_start);
`else
    logic unused_mdu;
    assign unused_mdu = &{1'b0, d_is_mdu, mdu_start};
    assign mdu_busy   = 1'b0;
    assign mdu_stall  = 1'b0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: instruction rows pushed with hand-derived
// expected outputs, popped and compared on the falling edge.
module tb_fwd_hazard_unit;

`ifdef FWD_MDU_EN
    localparam bit MDU = 1'b1;
`else
    localparam bit MDU = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] d_rs, d_rt, d_wreg;
    logic       d_use_rs, d_use_rt, d_pc8, d_is_mdu, mdu_start, flush;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       stall, fwd_rt_m, mdu_busy;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

    fwd_hazard_unit #(.AW(5), .TW(2), .MDU_LAT(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_wreg(d_wreg), .d_tnew(d_tnew),
        .d_pc8(d_pc8), .d_is_mdu(d_is_mdu), .mdu_start(mdu_start), .flush(flush),
        .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e),
        .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m), .mdu_busy(mdu_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs, rt;
        logic       urs, urt;
        logic [1:0] trs, trt;
        logic [4:0] wr;
        logic [1:0] tn;
        logic       pc8, mdu;
    } ins_t;

    typedef struct {
        string      tag;
        logic       stall;
        logic [1:0] frsd, frtd, frse, frte;
        logic       frtm, busy;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    function automatic ins_t op(input logic [4:0] rs, input logic [4:0] rt,
                                input logic urs, input logic urt,
                                input logic [1:0] trs, input logic [1:0] trt,
                                input logic [4:0] wr, input logic [1:0] tn,
                                input logic pc8, input logic mdu);
        ins_t i;
        i.rs = rs; i.rt = rt; i.urs = urs; i.urt = urt; i.trs = trs; i.trt = trt;
        i.wr = wr; i.tn = tn; i.pc8 = pc8; i.mdu = mdu;
        return i;
    endfunction

    task automatic cyc(input string tag, input ins_t i, input logic fl, input logic st,
                       input logic s, input logic [1:0] frsd, input logic [1:0] frtd,
                       input logic [1:0] frse, input logic [1:0] frte,
                       input logic frtm, input logic busy);
        exp_t e;
        @(posedge clk);
        #1;
        d_rs = i.rs; d_rt = i.rt; d_use_rs = i.urs; d_use_rt = i.urt;
        d_tuse_rs = i.trs; d_tuse_rt = i.trt; d_wreg = i.wr; d_tnew = i.tn;
        d_pc8 = i.pc8; d_is_mdu = i.mdu; flush = fl; mdu_start = st;
        e.tag = tag; e.stall = s; e.frsd = frsd; e.frtd = frtd;
        e.frse = frse; e.frte = frte; e.frtm = frtm; e.busy = busy;
        sb.push_back(e);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".stall"}, 32'(stall), 0);
        chk({tag, ".fwd_rs_d"}, 32'(fwd_rs_d), 0);
        chk({tag, ".fwd_rt_d"}, 32'(fwd_rt_d), 0);
        chk({tag, ".fwd_rs_e"}, 32'(fwd_rs_e), 0);
        chk({tag, ".fwd_rt_e"}, 32'(fwd_rt_e), 0);
        chk({tag, ".fwd_rt_m"}, 32'(fwd_rt_m), 0);
        chk({tag, ".mdu_busy"}, 32'(mdu_busy), 0);
    endtask

    task automatic mid_reset(input string tag);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk_zero(tag);
        #1 rst_n = 1'b1;
    endtask

    always @(negedge clk) begin : scoreboard
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.tag, ".stall"}, 32'(stall), 32'(e.stall));
            chk({e.tag, ".fwd_rs_d"}, 32'(fwd_rs_d), 32'(e.frsd));
            chk({e.tag, ".fwd_rt_d"}, 32'(fwd_rt_d), 32'(e.frtd));
            chk({e.tag, ".fwd_rs_e"}, 32'(fwd_rs_e), 32'(e.frse));
            chk({e.tag, ".fwd_rt_e"}, 32'(fwd_rt_e), 32'(e.frte));
            chk({e.tag, ".fwd_rt_m"}, 32'(fwd_rt_m), 32'(e.frtm));
            chk({e.tag, ".mdu_busy"}, 32'(mdu_busy), 32'(e.busy));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        ins_t nop_i, lw8, addu9, addu8, beq8, jal, jr31, addu10, lw0, use0, lw5, sw5, mflo;
        nop_i  = op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lw8    = op(1, 8, 1, 0, 1, 0, 8, 2, 0, 0);
        addu9  = op(8, 8, 1, 1, 1, 1, 9, 1, 0, 0);
        addu8  = op(2, 3, 1, 1, 1, 1, 8, 1, 0, 0);
        beq8   = op(8, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        jal    = op(0, 0, 0, 0, 0, 0, 31, 0, 1, 0);
        jr31   = op(31, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        addu10 = op(31, 0, 1, 1, 1, 1, 10, 1, 0, 0);
        lw0    = op(1, 0, 1, 0, 1, 0, 0, 2, 0, 0);
        use0   = op(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        lw5    = op(1, 5, 1, 0, 1, 0, 5, 2, 0, 0);
        sw5    = op(2, 5, 1, 1, 1, 2, 0, 0, 0, 0);
        mflo   = op(0, 0, 0, 0, 0, 0, 12, 1, 0, 1);

        // reset with hazardous-looking inputs applied
        d_rs = 8; d_rt = 8; d_use_rs = 1; d_use_rt = 1; d_tuse_rs = 0; d_tuse_rt = 0;
        d_wreg = 9; d_tnew = 2; d_pc8 = 0; d_is_mdu = 1; mdu_start = 1; flush = 0;
        #2 chk_zero("rst");
        #10 rst_n = 1'b1;
        repeat (2) cyc("idle", nop_i, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // load-use: one stall, then W->E forward on both operands
        cyc("t1_lw",   lw8,   0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t1_addu", addu9, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc("t1_hold", addu9, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t1_e",    nop_i, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        repeat (3) cyc("t1_tail", nop_i, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // ALU result to a branch in D
        cyc("t2_addu", addu8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t2_beq",  beq8,  0, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc("t2_hold", beq8,  0, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc("t2_e",    nop_i, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        repeat (3) cyc("t2_tail", nop_i, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // jal link value: M PC+8 into D, then into E
        cyc("t3_jal",  jal,   0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t3_gap",  nop_i, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t3_jr",   jr31,  0, 0, 0, 2, 0, 0, 0, 0, 0);
        cyc("t3_jr_e", nop_i, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        repeat (2) cyc("t3_tail", nop_i, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t3_jal2", jal,    0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t3_addu", addu10, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t3_e",    nop_i,  0, 0, 0, 0, 0, 3, 0, 0, 0);
        repeat (3) cyc("t3_tail2", nop_i, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // register 0 never creates a hazard
        cyc("t4_lw0",  lw0,   0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t4_use0", use0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) cyc("t4_tail", nop_i, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // load to store data: forwarded in M from W; squashed store gets nothing
        cyc("t5_lw",   lw5,   0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t5_sw",   sw5,   0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t5_e",    nop_i, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t5_m",    nop_i, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (2) cyc("t5_tail", nop_i, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t5f_lw",  lw5,   0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t5f_sw",  sw5,   1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t5f_e",   nop_i, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t5f_m",   nop_i, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) cyc("t5f_tail", nop_i, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // reset during a load-use stall drops the in-flight load
        cyc("r1_lw",   lw8,   0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("r1_addu", addu9, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        mid_reset("r1_mid");
        cyc("r1_after", addu9, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) cyc("r1_tail", nop_i, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // MDU: start cycle plus MDU_LAT busy cycles
        for (int k = 0; k < 7; k++)
            cyc($sformatf("t6_%0d", k), mflo, 0, k == 0, MDU && k < 6, 0, 0, 0, 0, 0,
                MDU && k >= 1 && k < 6);
        repeat (2) cyc("t6_tail", nop_i, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // restart while busy reloads the counter
        for (int k = 0; k < 9; k++)
            cyc($sformatf("t6r_%0d", k), mflo, 0, k == 0 || k == 2, MDU && k < 8,
                0, 0, 0, 0, 0, MDU && k >= 1 && k < 8);
        repeat (2) cyc("t6r_tail", nop_i, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // reset during an MDU stall clears busy at once
        cyc("t6x_0", mflo, 0, 1, MDU, 0, 0, 0, 0, 0, 0);
        cyc("t6x_1", mflo, 0, 0, MDU, 0, 0, 0, 0, 0, MDU);
        mid_reset("t6x_mid");
        cyc("t6x_after", mflo, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) cyc("t6x_tail", nop_i, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1 chk("sb_drained", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
